servant_trace_mon: RTL
======================

Name: servant_trace_mon

Overview:
Parametrised simulation/debug monitor for the servant SoC. It sits beside the core in the sim top and records retired-PC events (pc_adr/pc_vld) and GPIO output changes into a circular trace buffer. A trigger state machine freezes the buffer a programmable number of entries after a PC match. The bench reads the captured history back through a registered index port.

Parameters:
AW, 32, PC address width
CH, 1, number of GPIO channels monitored (1..AW)
DEPTH, 16, trace entries; power of two, >=4
POST_CNT, 4, entries recorded after the trigger entry before freezing (0..DEPTH-1)
TRIG_MODE, 1, 0 = free-running (trigger ignored), 1 = stop-on-trigger

Ports:
wb_clk  in  1  clock
wb_rst  in  1  asynchronous reset, active-high
pc_adr  in  AW  PC of the retired/fetched instruction
pc_vld  in  1  pc_adr valid this cycle
gpio  in  CH  GPIO outputs (q) of the SoC
trig_en  in  1  enable PC-match trigger
trig_adr  in  AW  trigger PC
rearm  in  1  single-cycle pulse: clear buffer and return to ARMED
rd_idx  in  log2(DEPTH)  read index; 0 = oldest valid entry
rd_data  out  AW+1  {kind, payload}; kind 0 = PC, 1 = GPIO value (zero-extended)
count  out  log2(DEPTH)+1  valid entries, saturates at DEPTH
total  out  32  entries written since rearm, wraps modulo 2^32
state  out  2  0 ARMED, 1 POST, 2 DONE
lost_evt  out  1  sticky: a pending GPIO event was overwritten

Behaviour:
- Reset (async, wb_rst=1): wr_ptr=0, count=0, total=0, state=ARMED, lost_evt=0, rd_data=0, pending cleared, gpio_q captured as 0. Buffer contents undefined; count=0 marks them invalid.
- GPIO change detect: gpio != gpio_q (gpio_q is the registered previous value) -> GPIO event carrying the new value.
- Write arbitration, one write per cycle, ARMED/POST only:
  - pc_vld=1: write PC entry. A simultaneous GPIO event goes into the pending register.
  - pc_vld=0, pending valid: write pending, clear it. A new GPIO event arriving that cycle becomes the new pending.
  - pc_vld=0, no pending, GPIO event: write GPIO entry directly.
  - GPIO event while pending is valid and not drained this cycle: overwrite pending with the newest value, set lost_evt.
- Each write: buf[wr_ptr]=entry; wr_ptr+1 mod DEPTH (wraps, overwrites oldest); count=min(count+1,DEPTH); total+1.
- State machine:
  - ARMED -> POST: TRIG_MODE=1, trig_en=1, pc_vld=1 and pc_adr==trig_adr. The trigger entry itself is written. post_left loads POST_CNT.
  - If POST_CNT=0, go directly to DONE instead.
  - POST: each write decrements post_left; the write that reaches 0 moves to DONE.
  - DONE: no writes; pending cleared; inputs ignored except rearm.
  - TRIG_MODE=0: stays ARMED forever.
- rearm (synchronous): wr_ptr=0, count=0, total=0, lost_evt=0, pending cleared, state=ARMED; no write that cycle. rearm wins over a simultaneous trigger or write.
- Readout: rd_data is registered, 1-cycle latency. rd_data <= buf[(wr_ptr - count + rd_idx) mod DEPTH]. rd_idx >= count returns 0. Reads are valid in any state and reflect the state after the same-cycle write.
- All pointer arithmetic is log2(DEPTH) bits with natural wrap.

Decomposition:
- Package servant_trace_pkg: state encoding (ARMED/POST/DONE), KIND_PC/KIND_GPIO constants, localparam function for index width.
- One sub-module servant_trace_ram: DEPTH x (AW+1) single-write, single registered-read array.
- Arbitration, pending register, counters and FSM stay in the top.

Test Plan:
(DEPTH=8, AW=32, CH=4, POST_CNT=2, TRIG_MODE=1 unless stated.)
1. Reset, then 3 pc_vld with PCs 0x00,0x04,0x08 -> count=3, total=3, rd_idx 0..2 read {0,0x00},{0,0x04},{0,0x08}, state=ARMED.
2. Wrap: 10 PCs 0x00..0x24, trigger disabled -> count=8, total=10, rd_idx0={0,0x08}, rd_idx7={0,0x24}.
3. Trigger: trig_adr=0x10, PCs 0x00..0x20 step 4 -> state goes POST after 0x10, DONE after 0x18. Last entry is 0x18, total=7, later PCs not recorded.
4. Simultaneous events:
   - gpio 0->5 in the same cycle as pc_vld 0x40, next cycle idle -> entries {0,0x40},{1,0x5}.
   - gpio 5->3->6 on consecutive cycles, all with pc_vld=1, then idle -> single {1,0x6} after the PCs, lost_evt=1.
5. rearm in DONE, same cycle as pc_vld 0x80 -> count=0, total=0, state=ARMED, lost_evt=0, 0x80 not recorded. Next PC 0x84 is rd_idx0.
6. Async reset mid-POST (wb_rst asserted between clock edges) -> outputs go to reset values immediately. TRIG_MODE=0 build given a matching PC stays ARMED.

Source files
------------

// File: rtl/servant_trace_pkg.sv
// Shared types and constants for the servant trace monitor: FSM encoding,
// entry kind tags and the index-width helper.
package servant_trace_pkg;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_POST  = 2'd1,
    ST_DONE  = 2'd2
  } trace_state_e;

  localparam logic KIND_PC   = 1'b0;
  localparam logic KIND_GPIO = 1'b1;

  function automatic int trace_idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/servant_trace_ram.sv
// Trace storage: one write port and one registered read port. A read of the
// address being written in the same cycle returns the new data.
module servant_trace_ram #(
  parameter int AW    = 32,
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] wa,
  input  logic [AW:0]   wd,
  input  logic [IW-1:0] ra,
  input  logic          rzero,
  output logic [AW:0]   rd
);

  logic [AW:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd <= '0;
    end else if (rzero) begin
      rd <= '0;
    end else if (we && (wa == ra)) begin
      rd <= wd;
    end else begin
      rd <= mem[ra];
    end
  end

endmodule

// File: rtl/servant_trace_mon.sv
// Circular trace of retired PCs and GPIO changes with a PC-match trigger that
// freezes the buffer POST_CNT entries after the trigger entry.
module servant_trace_mon
  import servant_trace_pkg::*;
#(
  parameter int AW        = 32,
  parameter int CH        = 1,
  parameter int DEPTH     = 16,
  parameter int POST_CNT  = 4,
  parameter int TRIG_MODE = 1
) (
  input  logic                              wb_clk,
  input  logic                              wb_rst,
  input  logic [AW-1:0]                     pc_adr,
  input  logic                              pc_vld,
  input  logic [CH-1:0]                     gpio,
  input  logic                              trig_en,
  input  logic [AW-1:0]                     trig_adr,
  input  logic                              rearm,
  input  logic [trace_idx_w(DEPTH)-1:0]     rd_idx,
  output logic [AW:0]                       rd_data,
  output logic [trace_idx_w(DEPTH):0]       count,
  output logic [31:0]                       total,
  output logic [1:0]                        state,
  output logic                              lost_evt
);

  localparam int IW = trace_idx_w(DEPTH);
  localparam logic [IW:0]   FULL     = (IW+1)'(DEPTH);
  localparam logic [IW-1:0] POST_LD  = IW'(POST_CNT);

  trace_state_e  st_q, st_nxt;
  logic [IW-1:0] wr_ptr_q, wr_ptr_nxt;
  logic [IW:0]   count_q, count_nxt;
  logic [31:0]   total_q, total_nxt;
  logic [IW-1:0] post_left_q, post_left_nxt;
  logic [CH-1:0] gpio_q;
  logic [CH-1:0] pend_q, pend_nxt;
  logic          pend_vld_q, pend_vld_nxt;
  logic          lost_q, lost_nxt;

  logic          gpio_evt;
  logic          active;
  logic          trig_hit;
  logic          we;
  logic [AW:0]   wdata;
  logic [AW-1:0] gpio_ext, pend_ext;
  logic [IW-1:0] ra;
  logic          rzero;

  always_comb begin
    gpio_ext           = '0;
    gpio_ext[CH-1:0]   = gpio;
    pend_ext           = '0;
    pend_ext[CH-1:0]   = pend_q;
  end

  assign gpio_evt = (gpio != gpio_q);
  assign active   = (st_q != ST_DONE) && !rearm;
  assign trig_hit = (TRIG_MODE == 1) && trig_en && pc_vld &&
                    (pc_adr == trig_adr) && (st_q == ST_ARMED) && !rearm;

  // Write arbitration: PC has priority, the pending GPIO slot holds one deferred event.
  always_comb begin
    we           = 1'b0;
    wdata        = '0;
    pend_nxt     = pend_q;
    pend_vld_nxt = pend_vld_q;
    lost_nxt     = lost_q;
    if (rearm) begin
      pend_vld_nxt = 1'b0;
      lost_nxt     = 1'b0;
    end else if (!active) begin
      pend_vld_nxt = 1'b0;
    end else if (pc_vld) begin
      we    = 1'b1;
      wdata = {KIND_PC, pc_adr};
      if (gpio_evt) begin
        if (pend_vld_q) lost_nxt = 1'b1;
        pend_nxt     = gpio;
        pend_vld_nxt = 1'b1;
      end
    end else if (pend_vld_q) begin
      we    = 1'b1;
      wdata = {KIND_GPIO, pend_ext};
      if (gpio_evt) begin
        pend_nxt = gpio;
      end else begin
        pend_vld_nxt = 1'b0;
      end
    end else if (gpio_evt) begin
      we    = 1'b1;
      wdata = {KIND_GPIO, gpio_ext};
    end
  end

  always_comb begin
    st_nxt        = st_q;
    post_left_nxt = post_left_q;
    unique case (st_q)
      ST_ARMED: begin
        if (trig_hit) begin
          post_left_nxt = POST_LD;
          st_nxt        = (POST_CNT == 0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (we) begin
          post_left_nxt = post_left_q - 1'b1;
          if (post_left_q == IW'(1)) st_nxt = ST_DONE;
        end
      end
      ST_DONE: st_nxt = ST_DONE;
      default: st_nxt = ST_ARMED;
    endcase
    if (rearm) st_nxt = ST_ARMED;
  end

  always_comb begin
    wr_ptr_nxt = wr_ptr_q;
    count_nxt  = count_q;
    total_nxt  = total_q;
    if (rearm) begin
      wr_ptr_nxt = '0;
      count_nxt  = '0;
      total_nxt  = '0;
    end else if (we) begin
      wr_ptr_nxt = wr_ptr_q + 1'b1;
      count_nxt  = (count_q == FULL) ? FULL : count_q + 1'b1;
      total_nxt  = total_q + 32'd1;
    end
  end

  // Read address uses post-write pointers so a read sees the same-cycle write.
  assign ra    = wr_ptr_nxt - count_nxt[IW-1:0] + rd_idx;
  assign rzero = ({1'b0, rd_idx} >= count_nxt);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      st_q        <= ST_ARMED;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      total_q     <= '0;
      post_left_q <= '0;
      gpio_q      <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      st_q        <= st_nxt;
      wr_ptr_q    <= wr_ptr_nxt;
      count_q     <= count_nxt;
      total_q     <= total_nxt;
      post_left_q <= post_left_nxt;
      gpio_q      <= gpio;
      pend_q      <= pend_nxt;
      pend_vld_q  <= pend_vld_nxt;
      lost_q      <= lost_nxt;
    end
  end

  servant_trace_ram #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .we    (we),
    .wa    (wr_ptr_q),
    .wd    (wdata),
    .ra    (ra),
    .rzero (rzero),
    .rd    (rd_data)
  );

  assign count    = count_q;
  assign total    = total_q;
  assign state    = st_q;
  assign lost_evt = lost_q;

endmodule
